phase_2b_derotate: RTL and testbench

//  Receive-side inverse of the 2-bit phase rotator. The rotator right-rotates a

---
 rtl/phase_pkg.sv | 29 ++
 rtl/phase_rotl.sv | 17 +
 rtl/phase_2b_derotate.sv | 141 ++++++++++++++
 tb/tb_phase_2b_derotate.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// Shared definitions for the 2-bit phase rotator and its receive-side derotator.
package phase_pkg;

  localparam int PHASE_W = 2;
  localparam int WORD_W  = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    TRY     = 3'd2,
    LOCKED  = 3'd3,
    FAIL    = 3'd4
  } phase_state_t;

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                             input logic [PHASE_W-1:0] k);
    logic [31:0] back;
    back = 32'(WORD_W) - 32'(k);
    return (x << k) | (x >> back);
  endfunction

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input logic [PHASE_W-1:0] k);
    logic [31:0] back;
    back = 32'(WORD_W) - 32'(k);
    return (x >> k) | (x << back);
  endfunction

endpackage

// File: rtl/phase_rotl.sv
// Combinational left rotate of a W-bit word by an AW-bit amount.
module phase_rotl #(
  parameter int W  = 64,
  parameter int AW = 2
) (
  input  logic [W-1:0]  x,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  y
);

  logic [31:0] back_s;

  // A shift of the full width yields zero, so amt=0 passes x through.
  assign back_s = 32'(W) - 32'(amt);
  assign y      = (x << amt) | (x >> back_s);

endmodule

// File: rtl/phase_2b_derotate.sv
// Recovers the transmit phase from one training beat, then left-rotates
// every later beat by the locked phase through a 1-entry output register.
module phase_2b_derotate
  import phase_pkg::*;
#(
  parameter int BITSTREAM = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cal_start,
  input  logic [BITSTREAM-1:0] train_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSTREAM-1:0] in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits,
  output logic [PHASE_W-1:0]   k_lock,
  output logic                 locked,
  output logic                 cal_fail
);

  localparam logic [PHASE_W-1:0] CAND_MAX = {PHASE_W{1'b1}};
  localparam logic [PHASE_W-1:0] CAND_ONE = PHASE_W'(1);

  phase_state_t           state_r, next_state_s;
  logic [PHASE_W-1:0]     cand_r;
  logic [PHASE_W-1:0]     k_lock_r;
  logic [BITSTREAM-1:0]   hold_r;
  logic [BITSTREAM-1:0]   out_bits_r;
  logic                   out_valid_r;
  logic [BITSTREAM-1:0]   try_rot_s;
  logic [BITSTREAM-1:0]   stream_rot_s;
  logic                   match_s;
  logic                   in_ready_s;
  logic                   in_hs_s;

  phase_rotl #(.W(BITSTREAM), .AW(PHASE_W)) u_try_rotl (
    .x   (hold_r),
    .amt (cand_r),
    .y   (try_rot_s)
  );

  phase_rotl #(.W(BITSTREAM), .AW(PHASE_W)) u_stream_rotl (
    .x   (in_bits),
    .amt (k_lock_r),
    .y   (stream_rot_s)
  );

  assign match_s = (try_rot_s == train_word);
  assign in_hs_s = in_valid && in_ready_s;

  // Input-side ready decode from the current state and output-register occupancy.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      CAPTURE: in_ready_s = 1'b1;
      LOCKED:  in_ready_s = !out_valid_r || out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Next-state logic; cal_start overrides every state.
  always_comb begin
    next_state_s = state_r;
    if (cal_start) begin
      next_state_s = CAPTURE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = IDLE;
        CAPTURE: next_state_s = in_hs_s ? TRY : CAPTURE;
        TRY: begin
          if (match_s) begin
            next_state_s = LOCKED;
          end else if (cand_r == CAND_MAX) begin
            next_state_s = FAIL;
          end else begin
            next_state_s = TRY;
          end
        end
        LOCKED:  next_state_s = LOCKED;
        FAIL:    next_state_s = FAIL;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State, candidate search, training hold and the streaming output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cand_r      <= {PHASE_W{1'b0}};
      k_lock_r    <= {PHASE_W{1'b0}};
      hold_r      <= {BITSTREAM{1'b0}};
      out_bits_r  <= {BITSTREAM{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (cal_start) begin
        // Any beat accepted alongside cal_start is discarded, and the held word dropped.
        cand_r      <= {PHASE_W{1'b0}};
        out_valid_r <= 1'b0;
      end else begin
        case (state_r)
          CAPTURE: begin
            if (in_hs_s) begin
              hold_r <= in_bits;
              cand_r <= {PHASE_W{1'b0}};
            end
          end
          TRY: begin
            if (match_s) begin
              k_lock_r <= cand_r;
            end else if (cand_r != CAND_MAX) begin
              cand_r <= cand_r + CAND_ONE;
            end
          end
          LOCKED: begin
            if (in_hs_s) begin
              out_bits_r  <= stream_rot_s;
              out_valid_r <= 1'b1;
            end else if (out_ready) begin
              out_valid_r <= 1'b0;
            end
          end
          default: begin
            out_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_bits  = out_bits_r;
  assign k_lock    = k_lock_r;
  assign locked    = (state_r == LOCKED);
  assign cal_fail  = (state_r == FAIL);

endmodule

// File: tb/tb_phase_2b_derotate.sv
// Directed bench: transmit rotator model -> phase_2b_derotate, calibration table plus stream/abort sequences.
module tb_phase_2b_derotate;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cal_start = 1'b0;
  logic [63:0] train_word = 64'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_bits = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_bits;
  logic [1:0]  k_lock;
  logic        locked;
  logic        cal_fail;

  int tests = 0;
  int fails = 0;

  phase_2b_derotate #(.BITSTREAM(64)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start), .train_word(train_word),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .k_lock(k_lock), .locked(locked), .cal_fail(cal_fail)
  );

  always #5 clk = ~clk;

  // Transmit-side right rotate, written independently of the design.
  function automatic logic [63:0] tx_rotr(input logic [63:0] x, input int k);
    logic [63:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = {r[0], r[63:1]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse cal_start, hand over one training beat, return edges from handshake to locked/cal_fail.
  task automatic calibrate(input logic [63:0] tw, input logic [63:0] iw, output int lat);
    train_word = tw;
    cal_start  = 1'b1;
    in_valid   = 1'b0;
    step();
    cal_start  = 1'b0;
    chk("capture_ready", in_ready, 1);
    in_valid = 1'b1;
    in_bits  = iw;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!(locked || cal_fail) && lat < 10) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] train;
    int          k_tx;
    bit          invert;
    logic [1:0]  exp_k;
    bit          exp_fail;
    int          exp_lat;
  } cal_vec_t;

  cal_vec_t    cal_tab [7];
  logic [63:0] exp_q [$];

  initial begin
    int          lat;
    int          idx;
    int          rcv;
    int          cyc;
    bit          acc;
    bit          ohs;
    bit          stall;
    logic [63:0] cur;
    logic [63:0] last;
    logic [63:0] prev;
    logic [63:0] e;

    // Lock at n means locked appears n+1 edges after the handshake edge.
    cal_tab[0] = '{"k3",     64'h0123_4567_89AB_CDEF, 3, 1'b0, 2'd3, 1'b0, 4};
    cal_tab[1] = '{"k0",     64'h0123_4567_89AB_CDEF, 0, 1'b0, 2'd0, 1'b0, 1};
    cal_tab[2] = '{"k1",     64'h0123_4567_89AB_CDEF, 1, 1'b0, 2'd1, 1'b0, 2};
    cal_tab[3] = '{"k2",     64'hFEDC_0000_0000_0001, 2, 1'b0, 2'd2, 1'b0, 3};
    cal_tab[4] = '{"sym_aa", 64'hAAAA_AAAA_AAAA_AAAA, 2, 1'b0, 2'd0, 1'b0, 1};
    cal_tab[5] = '{"sym_55", 64'h5555_5555_5555_5555, 3, 1'b0, 2'd1, 1'b0, 2};
    cal_tab[6] = '{"fail",   64'h0123_4567_89AB_CDEF, 0, 1'b1, 2'd0, 1'b1, 4};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_k_lock", k_lock, 0);
    chk("rst_locked", locked, 0);
    chk("rst_cal_fail", cal_fail, 0);
    in_valid = 1'b1;
    step();
    chk("idle_no_ready", in_ready, 0);
    in_valid = 1'b0;

    // Calibration table
    for (int i = 0; i < 7; i++) begin
      calibrate(cal_tab[i].train,
                cal_tab[i].invert ? ~cal_tab[i].train : tx_rotr(cal_tab[i].train, cal_tab[i].k_tx),
                lat);
      chk({cal_tab[i].name, "_lat"}, lat, cal_tab[i].exp_lat);
      chk({cal_tab[i].name, "_locked"}, locked, !cal_tab[i].exp_fail);
      chk({cal_tab[i].name, "_cal_fail"}, cal_fail, cal_tab[i].exp_fail);
      if (!cal_tab[i].exp_fail) chk({cal_tab[i].name, "_k"}, k_lock, cal_tab[i].exp_k);
      if (cal_tab[i].exp_fail) begin
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
          step();
          chk("fail_in_ready", in_ready, 0);
          chk("fail_hold", cal_fail, 1);
        end
        in_valid = 1'b0;
      end
    end

    // Stream 200 words at k=3 with random backpressure
    calibrate(64'h0123_4567_89AB_CDEF, tx_rotr(64'h0123_4567_89AB_CDEF, 3), lat);
    chk("stream_k", k_lock, 3);
    idx = 0; rcv = 0; cyc = 0;
    cur = {$urandom, $urandom};
    while ((idx < 200 || rcv < 200) && cyc < 3000) begin
      in_valid  = (idx < 200) && ($urandom_range(0, 3) != 0);
      in_bits   = tx_rotr(cur, 3);
      out_ready = (idx >= 200) ? 1'b1 : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc   = in_valid && in_ready;
      ohs   = out_valid && out_ready;
      stall = out_valid && !out_ready;
      prev  = out_bits;
      if (ohs) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_order", out_bits, e);
        end
        rcv++;
      end
      if (acc) begin
        exp_q.push_back(cur);
        last = cur;
        idx++;
        cur = {$urandom, $urandom};
      end
      step();
      cyc++;
      if (acc) begin
        chk("stream_lat_valid", out_valid, 1);
        chk("stream_lat_bits", out_bits, last);
      end else if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bits", out_bits, prev);
      end
    end
    in_valid = 1'b0;
    chk("stream_sent", idx, 200);
    chk("stream_rcvd", rcv, 200);
    chk("stream_queue_empty", exp_q.size(), 0);
    chk("stream_drained", out_valid, 0);

    // Abort while a word is stalled in the output register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = tx_rotr(64'hDEAD_BEEF_0BAD_F00D, 3);
    step();
    chk("abort_pre_valid", out_valid, 1);
    chk("abort_pre_bits", out_bits, 64'hDEAD_BEEF_0BAD_F00D);
    cal_start = 1'b1;
    in_bits   = 64'h1111_2222_3333_4444;
    step();
    cal_start = 1'b0;
    in_valid  = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_locked", locked, 0);
    chk("abort_capture", in_ready, 1);
    step();
    chk("abort_still_capture", in_ready, 1);
    calibrate(64'h0123_4567_89AB_CDEF, tx_rotr(64'h0123_4567_89AB_CDEF, 3), lat);
    chk("relock_lat", lat, 4);
    out_ready = 1'b1;
    step();
    chk("dropped_word", out_valid, 0);

    // Reset in the middle of TRY
    train_word = 64'h0123_4567_89AB_CDEF;
    cal_start  = 1'b1;
    step();
    cal_start = 1'b0;
    in_valid  = 1'b1;
    in_bits   = tx_rotr(64'h0123_4567_89AB_CDEF, 3);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("try_rst_in_ready", in_ready, 0);
    chk("try_rst_out_bits", out_bits, 0);
    chk("try_rst_k_lock", k_lock, 0);
    chk("try_rst_locked", locked, 0);
    chk("try_rst_cal_fail", cal_fail, 0);
    chk("try_rst_out_valid", out_valid, 0);
    repeat (4) step();
    chk("try_rst_stays_idle", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
